// File: rtl/switch_allocator_if.sv
// Switch-request / grant bundle shared by the input ports, the allocator and the crossbar.
// The allocator connects through the slave modport; the requesting side uses master.
interface switch_allocator_if #(
   parameter int NUM_PORTS = 5,
   parameter int SEL_W     = 3
);
   logic [NUM_PORTS-1:0]       sw_req_valid;
   logic [NUM_PORTS*SEL_W-1:0] sw_req_port;
   logic [NUM_PORTS-1:0]       sw_req_tail;
   logic [NUM_PORTS-1:0]       out_ready;
   logic [NUM_PORTS-1:0]       sw_grant;
   logic [NUM_PORTS*SEL_W-1:0] xbar_sel;
   logic [NUM_PORTS-1:0]       xbar_valid;
   logic                       sw_err;

   modport master (
      output sw_req_valid, sw_req_port, sw_req_tail, out_ready,
      input  sw_grant, xbar_sel, xbar_valid, sw_err
   );

   modport slave (
      input  sw_req_valid, sw_req_port, sw_req_tail, out_ready,
      output sw_grant, xbar_sel, xbar_valid, sw_err
   );
endinterface

// File: rtl/switch_allocator.sv
// Per-output round-robin switch allocator with wormhole locking; all outputs registered
// so they can drive the crossbar select lines directly.
module switch_allocator #(
   parameter int NUM_PORTS = 5,
   parameter int SEL_W     = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   switch_allocator_if.slave sa
);
   localparam logic [0:0]     ST_IDLE   = 1'b0;
   localparam logic [0:0]     ST_LOCKED = 1'b1;
   localparam logic [SEL_W:0] NP_W      = (SEL_W+1)'(NUM_PORTS);
   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_PORTS - 1);

   logic [0:0]                 state_q [NUM_PORTS];
   logic [0:0]                 state_d [NUM_PORTS];
   logic [SEL_W-1:0]           owner_q [NUM_PORTS];
   logic [SEL_W-1:0]           owner_d [NUM_PORTS];
   logic [SEL_W-1:0]           rr_q    [NUM_PORTS];
   logic [SEL_W-1:0]           rr_d    [NUM_PORTS];

   logic [SEL_W-1:0]           req_port_s [NUM_PORTS];
   logic [NUM_PORTS-1:0]       cand_s     [NUM_PORTS];
   logic [SEL_W-1:0]           win_s      [NUM_PORTS];
   logic [NUM_PORTS-1:0]       pinned_s;
   logic [NUM_PORTS-1:0]       gnt_s;
   logic                       err_s;

   logic [NUM_PORTS-1:0]       sw_grant_d, sw_grant_q;
   logic [NUM_PORTS-1:0]       xbar_valid_d, xbar_valid_q;
   logic [NUM_PORTS*SEL_W-1:0] xbar_sel_d, xbar_sel_q;
   logic                       sw_err_d, sw_err_q;

   // Split the packed request bus into one target index per input.
   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         req_port_s[i] = sa.sw_req_port[i*SEL_W +: SEL_W];
      end
   end

   // An input that owns a locked output but asks for a different one is pinned: never granted.
   always_comb begin
      pinned_s = '0;
      err_s    = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (sa.sw_req_valid[i] && (req_port_s[i] >= SEL_W'(NUM_PORTS))) begin
            err_s = 1'b1;
         end else begin
         end
         for (int o = 0; o < NUM_PORTS; o++) begin
            if (sa.sw_req_valid[i] && (state_q[o] == ST_LOCKED) &&
                (owner_q[o] == SEL_W'(i)) && (req_port_s[i] != SEL_W'(o))) begin
               pinned_s[i] = 1'b1;
               err_s       = 1'b1;
            end else begin
            end
         end
      end
      for (int o = 0; o < NUM_PORTS; o++) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            cand_s[o][i] = sa.sw_req_valid[i] && !pinned_s[i] && (req_port_s[i] == SEL_W'(o));
         end
      end
   end

   // Per-output arbitration and lock state transitions.
   always_comb begin
      logic           found;
      logic [SEL_W:0] sum;
      found = 1'b0;
      sum   = '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
         gnt_s[o]   = 1'b0;
         win_s[o]   = owner_q[o];
         state_d[o] = state_q[o];
         owner_d[o] = owner_q[o];
         rr_d[o]    = rr_q[o];
         found      = 1'b0;
         if (sa.out_ready[o]) begin
            case (state_q[o])
               ST_IDLE: begin
                  for (int k = 0; k < NUM_PORTS; k++) begin
                     sum = {1'b0, rr_q[o]} + (SEL_W+1)'(k);
                     if (sum >= NP_W) begin
                        sum = sum - NP_W;
                     end else begin
                     end
                     if (!found && cand_s[o][sum[SEL_W-1:0]]) begin
                        found    = 1'b1;
                        win_s[o] = sum[SEL_W-1:0];
                     end else begin
                     end
                  end
                  if (found) begin
                     gnt_s[o] = 1'b1;
                     rr_d[o]  = (win_s[o] == LAST_IDX) ? '0 : win_s[o] + 1'b1;
                     if (!sa.sw_req_tail[win_s[o]]) begin
                        state_d[o] = ST_LOCKED;
                        owner_d[o] = win_s[o];
                     end else begin
                        state_d[o] = ST_IDLE;
                     end
                  end else begin
                  end
               end
               ST_LOCKED: begin
                  if (cand_s[o][owner_q[o]]) begin
                     gnt_s[o] = 1'b1;
                     if (sa.sw_req_tail[owner_q[o]]) begin
                        state_d[o] = ST_IDLE;
                     end else begin
                        state_d[o] = ST_LOCKED;
                     end
                  end else begin
                  end
               end
               default: begin
                  state_d[o] = ST_IDLE;
               end
            endcase
         end else begin
         end
      end
   end

   // Fold per-output grants into per-input answers and crossbar selects; sel holds when idle.
   always_comb begin
      sw_grant_d   = '0;
      xbar_valid_d = gnt_s;
      xbar_sel_d   = xbar_sel_q;
      for (int o = 0; o < NUM_PORTS; o++) begin
         if (gnt_s[o]) begin
            sw_grant_d[win_s[o]]            = 1'b1;
            xbar_sel_d[o*SEL_W +: SEL_W]    = win_s[o];
         end else begin
         end
      end
      sw_err_d = sw_err_q | err_s;
   end

   // Arbiter state: lock flag, owner and round-robin pointer per output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int o = 0; o < NUM_PORTS; o++) begin
            state_q[o] <= ST_IDLE;
            owner_q[o] <= '0;
            rr_q[o]    <= '0;
         end
      end else begin
         for (int o = 0; o < NUM_PORTS; o++) begin
            state_q[o] <= state_d[o];
            owner_q[o] <= owner_d[o];
            rr_q[o]    <= rr_d[o];
         end
      end
   end

   // Registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_grant_q   <= '0;
         xbar_valid_q <= '0;
         xbar_sel_q   <= '0;
         sw_err_q     <= 1'b0;
      end else begin
         sw_grant_q   <= sw_grant_d;
         xbar_valid_q <= xbar_valid_d;
         xbar_sel_q   <= xbar_sel_d;
         sw_err_q     <= sw_err_d;
      end
   end

   assign sa.sw_grant   = sw_grant_q;
   assign sa.xbar_valid = xbar_valid_q;
   assign sa.xbar_sel   = xbar_sel_q;
   assign sa.sw_err     = sw_err_q;
endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: a per-cycle reference model plus literal checkpoints.
`timescale 1ns/1ps
module tb_switch_allocator;
   localparam int NP = 5;
   localparam int SW = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   bit   chk_en = 1'b0;

   switch_allocator_if #(.NUM_PORTS(NP), .SEL_W(SW)) sa ();
   switch_allocator #(.NUM_PORTS(NP), .SEL_W(SW)) dut (.clk(clk), .rst_n(rst_n), .sa(sa));

   always #5 clk = ~clk;

   // Reference model state and expected outputs.
   int          m_lock [NP];
   int          m_owner[NP];
   int          m_rr   [NP];
   logic [NP-1:0] e_gnt, e_valid;
   int          e_sel  [NP];
   bit          e_err;

   always @(posedge clk or negedge rst_n) begin
      int p[NP];
      bit pinned[NP];
      int best, bestd, d, w;
      if (!rst_n) begin
         for (int o = 0; o < NP; o++) begin
            m_lock[o] = 0; m_owner[o] = 0; m_rr[o] = 0; e_sel[o] = 0;
         end
         e_gnt = '0; e_valid = '0; e_err = 1'b0;
      end else begin
         e_gnt = '0; e_valid = '0;
         for (int i = 0; i < NP; i++) begin
            p[i] = int'(sa.sw_req_port[i*SW +: SW]);
            pinned[i] = 1'b0;
         end
         for (int i = 0; i < NP; i++)
            if (sa.sw_req_valid[i] && p[i] >= NP) e_err = 1'b1;
         for (int o = 0; o < NP; o++)
            if (m_lock[o] != 0 && sa.sw_req_valid[m_owner[o]] && p[m_owner[o]] != o) begin
               pinned[m_owner[o]] = 1'b1;
               e_err = 1'b1;
            end
         for (int o = 0; o < NP; o++) begin
            if (!sa.out_ready[o]) continue;
            if (m_lock[o] != 0) begin
               w = m_owner[o];
               if (sa.sw_req_valid[w] && p[w] == o) begin
                  e_gnt[w] = 1'b1; e_valid[o] = 1'b1; e_sel[o] = w;
                  if (sa.sw_req_tail[w]) m_lock[o] = 0;
               end
            end else begin
               best = -1; bestd = NP;
               for (int i = 0; i < NP; i++)
                  if (sa.sw_req_valid[i] && !pinned[i] && p[i] == o) begin
                     d = (i - m_rr[o] + NP) % NP;
                     if (d < bestd) begin bestd = d; best = i; end
                  end
               if (best >= 0) begin
                  e_gnt[best] = 1'b1; e_valid[o] = 1'b1; e_sel[o] = best;
                  m_rr[o] = (best + 1) % NP;
                  if (!sa.sw_req_tail[best]) begin m_lock[o] = 1; m_owner[o] = best; end
               end
            end
         end
      end
   end

   // Compare DUT against the model every cycle, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         n_checks++;
         if (sa.sw_grant !== e_gnt) begin
            n_fail++;
            $display("FAIL model sw_grant t=%0t got=%b want=%b", $time, sa.sw_grant, e_gnt);
         end
         n_checks++;
         if (sa.xbar_valid !== e_valid) begin
            n_fail++;
            $display("FAIL model xbar_valid t=%0t got=%b want=%b", $time, sa.xbar_valid, e_valid);
         end
         n_checks++;
         if (sa.sw_err !== e_err) begin
            n_fail++;
            $display("FAIL model sw_err t=%0t got=%b want=%b", $time, sa.sw_err, e_err);
         end
         for (int o = 0; o < NP; o++) begin
            n_checks++;
            if (sa.xbar_sel[o*SW +: SW] !== 3'(e_sel[o])) begin
               n_fail++;
               $display("FAIL model xbar_sel[%0d] t=%0t got=%0d want=%0d",
                        o, $time, sa.xbar_sel[o*SW +: SW], e_sel[o]);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic idle_all();
      sa.sw_req_valid = '0;
      sa.sw_req_port  = '0;
      sa.sw_req_tail  = '0;
   endtask

   task automatic req(input int i, input int p, input bit t);
      sa.sw_req_valid[i]         = 1'b1;
      sa.sw_req_port[i*SW +: SW] = 3'(p);
      sa.sw_req_tail[i]          = t;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [4:0] rot [4];
      rot[0] = 5'b00001; rot[1] = 5'b00010; rot[2] = 5'b01000; rot[3] = 5'b00001;

      idle_all();
      sa.out_ready = '1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset sw_grant", 32'(sa.sw_grant), 32'h0);
      chk("reset xbar_valid", 32'(sa.xbar_valid), 32'h0);
      chk("reset xbar_sel", 32'(sa.xbar_sel), 32'h0);
      chk("reset sw_err", 32'(sa.sw_err), 32'h0);
      rst_n = 1'b1;
      chk_en = 1'b1;

      // 1: single-flit packet, one-cycle latency, rr_ptr advances.
      req(0, 2, 1'b1);
      step();
      chk("t1 sw_grant", 32'(sa.sw_grant), 32'h01);
      chk("t1 xbar_valid", 32'(sa.xbar_valid), 32'h04);
      chk("t1 xbar_sel2", 32'(sa.xbar_sel[8:6]), 32'h0);
      idle_all();
      step();
      chk("t1 idle grant", 32'(sa.sw_grant), 32'h0);
      req(0, 2, 1'b1); req(1, 2, 1'b1);
      step();
      chk("t1 rr_ptr2 favours input1", 32'(sa.sw_grant), 32'h02);
      idle_all();

      // 2: round-robin rotation on output 4.
      req(0, 4, 1'b1); req(1, 4, 1'b1); req(3, 4, 1'b1);
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("t2 rotate %0d", k), 32'(sa.sw_grant), 32'(rot[k]));
      end
      idle_all();
      step();

      // 3: wormhole lock on output 0.
      req(1, 0, 1'b0); req(2, 0, 1'b1);
      step();
      chk("t3 head", 32'(sa.sw_grant), 32'h02);
      chk("t3 head sel0", 32'(sa.xbar_sel[2:0]), 32'h1);
      step();
      chk("t3 body1", 32'(sa.sw_grant), 32'h02);
      step();
      chk("t3 body2", 32'(sa.sw_grant), 32'h02);
      req(1, 0, 1'b1);
      step();
      chk("t3 tail", 32'(sa.sw_grant), 32'h02);
      sa.sw_req_valid[1] = 1'b0;
      step();
      chk("t3 input2 after tail", 32'(sa.sw_grant), 32'h04);
      chk("t3 input2 sel0", 32'(sa.xbar_sel[2:0]), 32'h2);
      idle_all();
      step();

      // 4: back-pressure on output 3.
      sa.out_ready = 5'b10111;
      req(4, 3, 1'b1);
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("t4 stalled grant %0d", k), 32'(sa.sw_grant), 32'h0);
         chk($sformatf("t4 stalled valid3 %0d", k), 32'(sa.xbar_valid[3]), 32'h0);
      end
      sa.out_ready = '1;
      step();
      chk("t4 released grant", 32'(sa.sw_grant), 32'h10);
      chk("t4 released valid", 32'(sa.xbar_valid), 32'h08);
      idle_all();
      step();

      // 5: five independent grants in one cycle.
      req(0, 1, 1'b1); req(1, 0, 1'b1); req(2, 3, 1'b1); req(3, 4, 1'b1); req(4, 2, 1'b1);
      step();
      chk("t5 sw_grant", 32'(sa.sw_grant), 32'h1f);
      chk("t5 xbar_valid", 32'(sa.xbar_valid), 32'h1f);
      chk("t5 xbar_sel", 32'(sa.xbar_sel), 32'h3501);
      idle_all();
      step();
      chk("t5 sel holds", 32'(sa.xbar_sel), 32'h3501);

      // 6: illegal requests, sticky error, reset mid-packet.
      chk("t6 err clear before", 32'(sa.sw_err), 32'h0);
      req(2, 6, 1'b1);
      step();
      chk("t6 port6 no grant", 32'(sa.sw_grant), 32'h0);
      chk("t6 port6 err", 32'(sa.sw_err), 32'h1);
      idle_all();
      req(3, 0, 1'b0);
      step();
      chk("t6 lock head", 32'(sa.sw_grant), 32'h08);
      req(3, 1, 1'b1);
      step();
      chk("t6 locked owner elsewhere grant", 32'(sa.sw_grant), 32'h0);
      chk("t6 locked owner elsewhere valid", 32'(sa.xbar_valid), 32'h0);
      chk("t6 err sticky", 32'(sa.sw_err), 32'h1);
      req(3, 0, 1'b0);
      step();
      chk("t6 body still owned", 32'(sa.sw_grant), 32'h08);
      #2 rst_n = 1'b0;
      #1;
      chk("t6 async reset grant", 32'(sa.sw_grant), 32'h0);
      chk("t6 async reset valid", 32'(sa.xbar_valid), 32'h0);
      chk("t6 async reset sel", 32'(sa.xbar_sel), 32'h0);
      chk("t6 async reset err", 32'(sa.sw_err), 32'h0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      req(3, 1, 1'b1);
      step();
      chk("t6 lock dropped by reset", 32'(sa.sw_grant), 32'h08);
      chk("t6 err after reset", 32'(sa.sw_err), 32'h0);
      idle_all();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
